// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between execute stage and muldiv_unit
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clear;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, clear, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, clear, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One multiplier/quotient bit per cycle over a shared 2*WIDTH accumulator.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_is_muldiv;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_is_muldiv = ~bus.op[2];
        // op[0]=0 selects the signed variant of both MULT and DIV
        w_a_neg     = ~bus.op[0] & bus.a[WIDTH-1];
        w_b_neg     = ~bus.op[0] & bus.b[WIDTH-1];
        w_a_abs     = w_a_neg ? -bus.a : bus.a;
        w_b_abs     = w_b_neg ? -bus.b : bus.b;

        // Multiply: upper half accumulates, lower half shifts the multiplier out
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Divide: upper half is the partial remainder, lower half dividend/quotient
        w_trial     = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
        w_div_next  = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

        // With a zero divisor the remainder ends as |a|; sign-correcting it restores a
        w_prod      = r_neg_res ? -r_acc : r_acc;
        w_quot      = r_div0 ? '1 : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
        w_rem       = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.clear) begin
                        if (w_is_muldiv) begin
                            r_state   <= S_RUN;
                            r_count   <= '0;
                            r_busy    <= 1'b1;
                            r_is_div  <= bus.op[1];
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            r_div0    <= bus.op[1] & (bus.b == '0);
                            r_acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? w_a_abs : w_b_abs)};
                            r_opnd    <= bus.op[1] ? w_b_abs : w_a_abs;
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.clear) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (r_count == LAST) begin
                            r_state <= S_FIX;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.clear) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in the execute stage beside the ALU and consumes the forwarded rs/rt operands, the same values the execute-stage bypass muxes feed the ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes HI/LO to the writeback mux for MFHI/MFLO and raises `busy` so the hazard unit can stall dependent instructions.

## Interface
Parameters:
- WIDTH, 32, operand width; even, ≥4. HI/LO are WIDTH bits each.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset
- start  in  1  issue strobe from execute stage; sampled on the rising edge
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op
- a  in  WIDTH  rs operand (dividend / multiplicand / MT source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- clear  in  1  synchronous flush of an in-flight operation (exception or branch flush)
- busy  out  1  operation in flight; hazard unit stalls MFHI/MFLO/mul/div while busy=1
- done  out  1  one-cycle pulse: HI/LO just updated by a MUL/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Clock and reset: one clock `clk`. Reset is asynchronous, active-low, on `reset`.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- States:
  - IDLE
  - RUN (WIDTH iterations)
  - FIX (sign correction and HI/LO writeback)
- IDLE transitions:
  - start=1, op∈{MULT, MULTU, DIV, DIVU}: latch operands and op; go to RUN with count=0.
    - Signed ops latch |a| and |b| and record the result signs.
  - start=1, op=MTHI: hi←a on that edge. State stays IDLE; no busy, no done.
  - start=1, op=MTLO: lo←a on that edge. State stays IDLE; no busy, no done.
  - start=1, op=110/111: ignored.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- RUN, divide: restoring divide, one quotient bit per cycle.
- RUN exit: after iteration WIDTH (count wraps from WIDTH-1), go to FIX.
- FIX:
  - Apply sign correction:
    - Product is negated if the signs differed.
    - Quotient is negated if the signs differed.
    - Remainder takes the dividend's sign.
  - Multiply writeback: hi←product[2W-1:W], lo←product[W-1:0].
  - Divide writeback: lo←quotient, hi←remainder.
  - Go to IDLE; done=1 for the following cycle.
- Signed division truncates toward zero.
- Divide by zero (b=0), signed or unsigned: lo←all ones, hi←a (original, uncorrected). Full latency still applies.
- Signed overflow (a=most-negative, b=−1): lo←a (0x80000000 for WIDTH=32), hi←0.
- start while busy=1: ignored; the in-flight operation is not disturbed. The hazard unit must hold the instruction.
- clear=1 in RUN or FIX: go to IDLE next edge.
  - hi/lo keep their previous values; busy drops; no done pulse.
- clear=1 in IDLE: the start on that edge is discarded, including MTHI/MTLO. Clear wins over start.
- Reset mid-operation: the operation is abandoned immediately and all reset values apply.

## Timing
- Edge E0 samples start=1 for a MUL/DIV; busy=1 from just after E0.
- Iterations occur on edges E1..E_WIDTH; the FIX writeback occurs on E_(WIDTH+1).
- After E_(WIDTH+1): hi/lo hold the new result, busy=0, done=1 for one cycle.
- MUL/DIV latency is WIDTH+1 edges from the start edge: 33 for WIDTH=32.
- A new start is accepted on E_(WIDTH+1)+1 at the earliest; back-to-back ops have zero dead cycles beyond busy.
- MTHI/MTLO: hi/lo updated on the start edge itself; visible the next cycle.
- hi, lo, busy and done are registered outputs; there is no combinational path from the inputs.

## Test plan
- MULTU a=FFFFFFFF, b=FFFFFFFF → after 33 edges hi=FFFFFFFE, lo=00000001; done pulses once; busy high for exactly 33 cycles.
- MULT a=FFFFFFFD (−3), b=00000005 → hi=FFFFFFFF, lo=FFFFFFF1. MULT a=80000000, b=80000000 → hi=40000000, lo=00000000.
- DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=7, b=2 → lo=3, hi=1.
- DIVU a=7, b=0 → lo=FFFFFFFF, hi=7.
- DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- MTHI a=12345678, then MULTU 2×3 with a second start (MTLO) at E10 → second start ignored; final hi=0, lo=6.
- MULTU in flight, clear at E15 → busy=0 after E16, hi/lo unchanged from pre-op values (preload hi=AAAAAAAA via MTHI), no done.
- clear and start same edge → nothing issued.
- reset=0 asserted asynchronously at mid-cycle during RUN of DIVU 100/7 → hi=lo=0 and busy=0 immediately. After release, DIVU 100/7 re-issued → lo=14, hi=2.
